// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display blocks: active-low segment
// patterns {g,f,e,d,c,b,a}, the all-off anode value and the digit-state encoding.
package seg7_pkg;

    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_1   = 7'b1111001;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_3   = 7'b0110000;
    localparam logic [6:0] SEG_4   = 7'b0011001;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_6   = 7'b0000010;
    localparam logic [6:0] SEG_7   = 7'b1111000;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0010000;
    localparam logic [6:0] SEG_A   = 7'b0001000;
    localparam logic [6:0] SEG_B   = 7'b0000011;
    localparam logic [6:0] SEG_C   = 7'b1000110;
    localparam logic [6:0] SEG_D   = 7'b0100001;
    localparam logic [6:0] SEG_E   = 7'b0000110;
    localparam logic [6:0] SEG_F   = 7'b0001110;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [3:0] AN_OFF  = 4'hF;

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } dig_e;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}.
module hex_to_7seg
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        unique case (nib_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Scans a 16-bit hex value onto a 4-digit common-anode display, one digit per
// prescaler period, with a per-scan shadow copy, leading-zero blanking and DPs.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned CNT_W       = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        en,
    input  logic        blank_lz,
    input  logic [3:0]  dp_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam logic [CNT_W-1:0] PRESC_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] presc_q, presc_d;
    dig_e             dig_q, dig_d;
    logic [15:0]      shadow_q, shadow_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic             tick;
    logic [3:0]       nib;
    logic [6:0]       nib_seg;
    logic [3:0]       an_sel;
    logic             blanked;
    logic             dp_req;
    logic             lit;

    assign tick = (presc_q == PRESC_MAX);

    always_comb begin
        presc_d  = tick ? '0 : presc_q + CNT_W'(1);
        dig_d    = dig_q;
        shadow_d = shadow_q;
        if (tick) begin
            unique case (dig_q)
                DIG0: dig_d = DIG1;
                DIG1: dig_d = DIG2;
                DIG2: dig_d = DIG3;
                DIG3: begin
                    dig_d    = DIG0;
                    shadow_d = value;
                end
            endcase
        end
    end

    // Digit k blanks only when it and every more-significant nibble are zero.
    always_comb begin
        nib     = '0;
        an_sel  = AN_OFF;
        blanked = 1'b0;
        dp_req  = 1'b0;
        unique case (dig_q)
            DIG0: begin
                nib    = shadow_q[3:0];
                an_sel = 4'b1110;
                dp_req = dp_en[0];
            end
            DIG1: begin
                nib     = shadow_q[7:4];
                an_sel  = 4'b1101;
                blanked = blank_lz && (shadow_q[15:4] == '0);
                dp_req  = dp_en[1];
            end
            DIG2: begin
                nib     = shadow_q[11:8];
                an_sel  = 4'b1011;
                blanked = blank_lz && (shadow_q[15:8] == '0);
                dp_req  = dp_en[2];
            end
            DIG3: begin
                nib     = shadow_q[15:12];
                an_sel  = 4'b0111;
                blanked = blank_lz && (shadow_q[15:12] == '0);
                dp_req  = dp_en[3];
            end
        endcase
    end

    hex_to_7seg u_dec (
        .nib_i (nib),
        .seg_o (nib_seg)
    );

    assign lit  = en && !blanked;
    assign an_d  = lit ? an_sel : AN_OFF;
    assign seg_d = nib_seg;
    assign dp_d  = lit ? ~dp_req : 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q  <= '0;
            dig_q    <= DIG0;
            shadow_q <= '0;
            an_q     <= AN_OFF;
            seg_q    <= SEG_OFF;
            dp_q     <= 1'b1;
        end else begin
            presc_q  <= presc_d;
            dig_q    <= dig_d;
            shadow_q <= shadow_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV=4 (16-cycle scan).
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic        en;
    logic        blank_lz;
    logic [3:0]  dp_en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned ncyc     = 0;

    typedef struct {
        logic [15:0]      value;
        logic             en;
        logic             blz;
        logic [3:0]       dpe;
        logic [3:0][3:0]  an;
        logic [3:0][6:0]  seg;
        logic [3:0]       dp;
    } vec_t;

    vec_t vecs[11];

    seg7_scan_driver #(.REFRESH_DIV(4), .CNT_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .value    (value),
        .en       (en),
        .blank_lz (blank_lz),
        .dp_en    (dp_en),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic vec_t mk(input logic [15:0] v, input logic e, input logic b,
                                input logic [3:0] d, input logic [15:0] a,
                                input logic [27:0] s, input logic [3:0] p);
        vec_t r;
        r.value = v; r.en = e; r.blz = b; r.dpe = d;
        r.an = a; r.seg = s; r.dp = p;
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
        ncyc++;
    endtask

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: an/seg/dp got %b_%b_%b required %b_%b_%b", name,
                     act[11:8], act[7:1], act[0], exp[11:8], exp[7:1], exp[0]);
        end
    endtask

    // Advance to the load edge of the next scan so the following 16 cycles show the new value.
    task automatic align();
        int unsigned start;
        bit found;
        start = ncyc;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc();
            if (ncyc % 16 == 0 && ncyc > start) found = 1'b1;
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL align: scan boundary not reached, got cycle %0d required multiple of 16", ncyc);
        end
    endtask

    function automatic logic [3:0] an_of(input int unsigned n);
        logic [3:0] r;
        r = 4'b1111;
        r[((n - 1) / 4) % 4] = 1'b0;
        return r;
    endfunction

    initial begin
        // {slot3, slot2, slot1, slot0}
        vecs[0]  = mk(16'h1A2F, 1, 0, 4'b0000, {4'b0111,4'b1011,4'b1101,4'b1110},
                      {7'b1111001,7'b0001000,7'b0100100,7'b0001110}, 4'b1111);
        vecs[1]  = mk(16'h0040, 1, 1, 4'b0000, {4'b1111,4'b1111,4'b1101,4'b1110},
                      {7'b1000000,7'b1000000,7'b0011001,7'b1000000}, 4'b1111);
        vecs[2]  = mk(16'h0000, 1, 1, 4'b0000, {4'b1111,4'b1111,4'b1111,4'b1110},
                      {7'b1000000,7'b1000000,7'b1000000,7'b1000000}, 4'b1111);
        vecs[3]  = mk(16'h1A2F, 1, 0, 4'b0100, {4'b0111,4'b1011,4'b1101,4'b1110},
                      {7'b1111001,7'b0001000,7'b0100100,7'b0001110}, 4'b1011);
        vecs[4]  = mk(16'h0040, 1, 1, 4'b1111, {4'b1111,4'b1111,4'b1101,4'b1110},
                      {7'b1000000,7'b1000000,7'b0011001,7'b1000000}, 4'b1100);
        vecs[5]  = mk(16'h8888, 0, 0, 4'b1111, {4'b1111,4'b1111,4'b1111,4'b1111},
                      {7'b0000000,7'b0000000,7'b0000000,7'b0000000}, 4'b1111);
        vecs[6]  = mk(16'h0000, 1, 0, 4'b0000, {4'b0111,4'b1011,4'b1101,4'b1110},
                      {7'b1000000,7'b1000000,7'b1000000,7'b1000000}, 4'b1111);
        vecs[7]  = mk(16'hC0E0, 1, 1, 4'b0000, {4'b0111,4'b1011,4'b1101,4'b1110},
                      {7'b1000110,7'b1000000,7'b0000110,7'b1000000}, 4'b1111);
        vecs[8]  = mk(16'h9B7D, 1, 0, 4'b0000, {4'b0111,4'b1011,4'b1101,4'b1110},
                      {7'b0010000,7'b0000011,7'b1111000,7'b0100001}, 4'b1111);
        vecs[9]  = mk(16'h3865, 1, 0, 4'b0000, {4'b0111,4'b1011,4'b1101,4'b1110},
                      {7'b0110000,7'b0000000,7'b0000010,7'b0010010}, 4'b1111);
        vecs[10] = mk(16'h0007, 1, 1, 4'b0000, {4'b1111,4'b1111,4'b1111,4'b1110},
                      {7'b1000000,7'b1000000,7'b1000000,7'b1111000}, 4'b1111);

        // Reset for two cycles with a nonzero value on the bus.
        rst = 1'b1; value = 16'h1234; en = 1'b1; blank_lz = 1'b0; dp_en = 4'b0000;
        cyc();
        check("reset_c1", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
        cyc();
        check("reset_c2", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
        rst = 1'b0;
        ncyc = 0;
        check("release_lag", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
        cyc();
        check("first_digit", {an, seg, dp}, {4'b1110, 7'b1000000, 1'b1});

        for (int v = 0; v < 11; v++) begin
            value = vecs[v].value; en = vecs[v].en;
            blank_lz = vecs[v].blz; dp_en = vecs[v].dpe;
            align();
            for (int s = 0; s < 4; s++) begin
                for (int c = 0; c < 4; c++) begin
                    cyc();
                    check($sformatf("vec%0d_slot%0d_c%0d", v, s, c), {an, seg, dp},
                          {vecs[v].an[s], vecs[v].seg[s], vecs[v].dp[s]});
                end
            end
        end

        // Tear-free: value changes during the DIG1 slot, visible only after the wrap.
        value = 16'h1111; en = 1'b1; blank_lz = 1'b0; dp_en = 4'b0000;
        align();
        for (int i = 0; i < 6; i++) cyc();
        check("tear_pre", {an, seg, dp}, {4'b1101, 7'b1111001, 1'b1});
        value = 16'h2222;
        for (int i = 0; i < 10; i++) begin
            cyc();
            check($sformatf("tear_old_%0d", i), {an, seg, dp}, {an_of(ncyc), 7'b1111001, 1'b1});
        end
        for (int i = 0; i < 16; i++) begin
            cyc();
            check($sformatf("tear_new_%0d", i), {an, seg, dp}, {an_of(ncyc), 7'b0100100, 1'b1});
        end

        // Enable drop in the digit-2 slot; scan timing keeps running underneath.
        value = 16'h1A2F; dp_en = 4'b0100;
        align();
        for (int i = 0; i < 9; i++) cyc();
        check("en_lit_dp", {an, seg, dp}, {4'b1011, 7'b0001000, 1'b0});
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check($sformatf("en_off_%0d", i), {7'b0, an, dp}, {7'b0, 4'b1111, 1'b1});
        end
        en = 1'b1;
        cyc();
        check("en_back_dig3", {an, seg, dp}, {4'b0111, 7'b1111001, 1'b1});
        cyc();
        cyc();
        check("en_back_dig0", {an, seg, dp}, {4'b1110, 7'b0001110, 1'b1});

        // Reset in the DIG2 slot aborts the scan and clears the shadow.
        dp_en = 4'b0000;
        align();
        for (int i = 0; i < 10; i++) cyc();
        check("mid_pre", {an, seg, dp}, {4'b1011, 7'b0001000, 1'b1});
        rst = 1'b1;
        cyc();
        check("mid_reset", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
        rst = 1'b0;
        ncyc = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check($sformatf("mid_restart_%0d", i), {an, seg, dp}, {4'b1110, 7'b1000000, 1'b1});
        end
        cyc();
        check("mid_dig1", {an, seg, dp}, {4'b1101, 7'b1000000, 1'b1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
